// File: rtl/bus_wrr_arbiter_pkg.sv
// Shared definitions for the weighted round-robin bus arbiter.
//   bus_owner_t       : 2-bit bus owner index encoding (BUS_OWNER_MASTER_0..3)
//   BUS_ARB_W_DEFAULT : default tenure (cycles) for every master
//   ENABLE_/DISABLE_  : active-low asserted/deasserted levels
//   RESET_ENABLE      : asserted level of the synchronous reset
//   owner_grants_n()  : one-hot active-low grant vector for an owner index
package bus_wrr_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_OWNER_MASTER_0 = 2'd0,
        BUS_OWNER_MASTER_1 = 2'd1,
        BUS_OWNER_MASTER_2 = 2'd2,
        BUS_OWNER_MASTER_3 = 2'd3
    } bus_owner_t;

    localparam int unsigned BUS_ARB_W_DEFAULT = 4;

    localparam logic ENABLE_      = 1'b0;
    localparam logic DISABLE_     = 1'b1;
    localparam logic RESET_ENABLE = 1'b1;

    // Exactly one grant low: the one belonging to the owner.
    function automatic logic [3:0] owner_grants_n(input logic [1:0] owner);
        logic [3:0] g;
        g        = {4{DISABLE_}};
        g[owner] = ENABLE_;
        return g;
    endfunction

endpackage

// File: rtl/bus_wrr_arbiter_rr_pick.sv
// Round-robin successor search (combinational).
//   owner      in  2  current owner index
//   req_vec    in  4  requests, active-high
//   nxt        out 2  first requester after owner in order owner+1..owner+3
//   others_req out 1  any non-owner request asserted
module bus_rr_pick (
    input  logic [1:0] owner,
    input  logic [3:0] req_vec,
    output logic [1:0] nxt,
    output logic       others_req
);

    logic [1:0] cand;

    // Walk the RR order farthest-first so the nearest requester wins last.
    always_comb begin
        nxt        = owner;
        others_req = 1'b0;
        cand       = 2'd0;
        for (int i = 3; i >= 1; i--) begin
            cand = owner + 2'(i);
            if (req_vec[cand]) begin
                nxt        = cand;
                others_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_wrr_arbiter.sv
// Weighted round-robin arbiter for the 4-master shared bus. Each owner keeps
// the bus for at most its weight in cycles while others wait, then ownership
// rotates to the next requester.
// Optional feature macro: BUS_ARB_LOCK_EN (adds m*_lock_ tenure-lock inputs).
//   clk                 in  1  clock
//   reset               in  1  synchronous, active-high
//   m0_req_..m3_req_    in  1  bus request, active-low
//   m0_grnt_..m3_grnt_  out 1  bus grant, active-low, exactly one low
//   owner               out 2  current owner index
//   preempt             out 1  pulse: ownership moved on quota expiry
//   m0_lock_..m3_lock_  in  1  tenure lock, active-low (BUS_ARB_LOCK_EN only)
module bus_wrr_arbiter
    import bus_wrr_arbiter_pkg::*;
#(
    parameter int unsigned QW = 4,
    parameter int unsigned W0 = BUS_ARB_W_DEFAULT,
    parameter int unsigned W1 = BUS_ARB_W_DEFAULT,
    parameter int unsigned W2 = BUS_ARB_W_DEFAULT,
    parameter int unsigned W3 = BUS_ARB_W_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       preempt
`ifdef BUS_ARB_LOCK_EN
    ,
    input  logic       m0_lock_,
    input  logic       m1_lock_,
    input  logic       m2_lock_,
    input  logic       m3_lock_
`endif
);

    localparam int unsigned W_MAX = 1 << QW;

    // Weights must be loadable as W-1 into a QW-bit counter.
    if (W0 < 1 || W0 > W_MAX || W1 < 1 || W1 > W_MAX ||
        W2 < 1 || W2 > W_MAX || W3 < 1 || W3 > W_MAX) begin : g_bad_weight
        $error("bus_wrr_arbiter: weights must lie in 1..2**QW");
    end

    logic [1:0]    owner_q, owner_d;
    logic [QW-1:0] cnt_q,   cnt_d;
    logic          preempt_q, preempt_d;

    logic [3:0]    req_vec;
    logic [1:0]    nxt;
    logic          others_req;
    logic          oreq;
    logic          olock;
    logic [QW-1:0] wm1 [4];

    assign req_vec = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign oreq    = req_vec[owner_q];

`ifdef BUS_ARB_LOCK_EN
    logic [3:0] lock_vec;
    assign lock_vec = ~{m3_lock_, m2_lock_, m1_lock_, m0_lock_};
    // Lock only counts when the owner is also requesting.
    assign olock    = oreq & lock_vec[owner_q];
`else
    assign olock    = 1'b0;
`endif

    // Reload values: tenure W means W-1 further cycles after the first.
    assign wm1[0] = QW'(W0 - 1);
    assign wm1[1] = QW'(W1 - 1);
    assign wm1[2] = QW'(W2 - 1);
    assign wm1[3] = QW'(W3 - 1);

    bus_rr_pick u_rr_pick (
        .owner      (owner_q),
        .req_vec    (req_vec),
        .nxt        (nxt),
        .others_req (others_req)
    );

    // Tenure accounting and ownership hand-over.
    always_comb begin
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        if (oreq) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - QW'(1);
            end else if (others_req && !olock) begin
                owner_d   = nxt;
                cnt_d     = wm1[nxt];
                preempt_d = 1'b1;
            end
            // otherwise: quota spent but nobody waiting (or locked) -> hold at 0
        end else if (others_req) begin
            owner_d = nxt;
            cnt_d   = wm1[nxt];
        end else begin
            cnt_d = wm1[owner_q];
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            owner_q   <= 2'(BUS_OWNER_MASTER_0);
            cnt_q     <= wm1[0];
            preempt_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign owner   = owner_q;
    assign preempt = preempt_q;
    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = owner_grants_n(owner_q);

endmodule
